// File: rtl/mux_ser_pkg.sv
// mux_serializer shared types: widths, FSM state encoding, parity helper.
// PAR is always declared; it is only reachable when PARITY_EN is defined.
package mux_ser_pkg;

  localparam int WIDTH = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_e;

  function automatic logic even_par(
    input logic [0:WIDTH-1] w
  );
    return ^w;
  endfunction

endpackage

// File: rtl/mux_serializer_sel_mux.sv
// sel_mux: WIDTH-to-1 combinational mux, f = w[s].
// Index 0 of w is the leftmost (most significant) bit of a literal.
module sel_mux #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic [0:WIDTH-1] w,
  input  logic [SEL_W-1:0] s,
  output logic             f
);

  assign f = w[s];

endmodule

// File: rtl/mux_serializer.sv
// mux_serializer: 16-bit word in, one selected bit per beat out.
// Optional even-parity trailer beat when PARITY_EN is defined.
module mux_serializer #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_last
);

  import mux_ser_pkg::*;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

  state_e           state;
  logic [0:WIDTH-1] held;
  logic [SEL_W-1:0] sel;
  logic             mux_bit;
  logic             is_idle;
  logic             is_shift;
  logic             is_par;
  logic             at_last;
  logic             ready_core;
  logic             take;

  sel_mux #(
    .WIDTH(WIDTH),
    .SEL_W(SEL_W)
  ) u_sel_mux (
    .w(held),
    .s(sel),
    .f(mux_bit)
  );

  assign is_idle  = (state == IDLE);
  assign is_shift = (state == SHIFT);
  assign is_par   = (state == PAR);
  assign at_last  = (sel == LAST);

  assign out_valid = is_shift | is_par;
  assign out_sel   = sel;

`ifdef PARITY_EN
  assign out_last   = is_par;
  assign ready_core = is_idle
                    | (is_par & out_ready);

  always_comb begin
    out_bit = 1'b0;
    unique case (1'b1)
      is_shift: out_bit = mux_bit;
      is_par:   out_bit = even_par(held);
      default:  out_bit = 1'b0;
    endcase
  end
`else
  assign out_last   = is_shift & at_last;
  assign ready_core = is_idle
                    | (out_last & out_ready);
  assign out_bit    = is_shift & mux_bit;
`endif

  // rst_n gates only the visible ready; flops see the ungated term
  assign in_ready = rst_n & ready_core;
  assign take     = in_valid & ready_core;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      held  <= '0;
      sel   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            held  <= in_data;
            sel   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (out_ready) begin
            if (!at_last) begin
              sel <= sel + SEL_W'(1);
            end else begin
`ifdef PARITY_EN
              state <= PAR;
`else
              sel <= '0;
              if (take) begin
                held  <= in_data;
                state <= SHIFT;
              end else begin
                state <= IDLE;
              end
`endif
            end
          end
        end
        PAR: begin
`ifdef PARITY_EN
          if (out_ready) begin
            sel <= '0;
            if (take) begin
              held  <= in_data;
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
`else
          state <= IDLE;
          sel   <= '0;
`endif
        end
        default: begin
          state <= IDLE;
          sel   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_serializer.sv
// Directed bench for mux_serializer: vector table plus hand sequences.
// Expectations track PARITY_EN when the bench is built with it.
module tb_mux_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [0:15] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_bit;
  logic [3:0]  out_sel;
  logic        out_last;

  int n_chk;
  int n_fail;

`ifdef PARITY_EN
  localparam logic LAST15 = 1'b0;
`else
  localparam logic LAST15 = 1'b1;
`endif

  typedef struct {
    logic [15:0] word;
    logic [0:15] bits;
    logic        par;
  } vec_t;

  vec_t vecs[7];

  mux_serializer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bit  (out_bit),
    .out_sel  (out_sel),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic beat_chk(
    input string nm,
    input int    i,
    input logic  eb
  );
    chk($sformatf("%s b%0d valid", nm, i), 32'(out_valid), 1);
    chk($sformatf("%s b%0d sel", nm, i), 32'(out_sel), i);
    chk($sformatf("%s b%0d bit", nm, i), 32'(out_bit), 32'(eb));
    chk($sformatf("%s b%0d last", nm, i), 32'(out_last),
        (i == 15) ? 32'(LAST15) : 0);
  endtask

  task automatic par_chk(input string nm, input logic ep);
`ifdef PARITY_EN
    chk({nm, " par valid"}, 32'(out_valid), 1);
    chk({nm, " par sel"}, 32'(out_sel), 15);
    chk({nm, " par bit"}, 32'(out_bit), 32'(ep));
    chk({nm, " par last"}, 32'(out_last), 1);
`else
    chk({nm, " no par beat"}, 32'(out_valid), 0);
    chk({nm, " par unused"}, 32'(ep), 32'(ep ^ 1'b0));
    n_chk--;
`endif
  endtask

  task automatic idle_chk(input string nm);
    chk({nm, " idle valid"}, 32'(out_valid), 0);
    chk({nm, " idle ready"}, 32'(in_ready), 1);
    chk({nm, " idle sel"}, 32'(out_sel), 0);
    chk({nm, " idle bit"}, 32'(out_bit), 0);
  endtask

  task automatic run_word(
    input string       nm,
    input logic [15:0] w,
    input logic [0:15] eb,
    input logic        ep
  );
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = w;
    out_ready = 1'b1;
    #1;
    chk({nm, " load ready"}, 32'(in_ready), 1);
    chk({nm, " load valid"}, 32'(out_valid), 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      #1;
      beat_chk(nm, i, eb[i]);
    end
`ifdef PARITY_EN
    @(negedge clk);
    #1;
    par_chk(nm, ep);
`endif
    @(negedge clk);
    #1;
    idle_chk(nm);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    vecs[0] = '{16'hACF1, 16'b1010_1100_1111_0001, 1'b1};
    vecs[1] = '{16'hCBE3, 16'b1100_1011_1110_0011, 1'b0};
    vecs[2] = '{16'h0000, 16'b0000_0000_0000_0000, 1'b0};
    vecs[3] = '{16'hFFFF, 16'b1111_1111_1111_1111, 1'b0};
    vecs[4] = '{16'h8001, 16'b1000_0000_0000_0001, 1'b0};
    vecs[5] = '{16'h0100, 16'b0000_0001_0000_0000, 1'b1};
    vecs[6] = '{16'h7FFE, 16'b0111_1111_1111_1110, 1'b0};

    #2;
    chk("rst valid", 32'(out_valid), 0);
    chk("rst ready", 32'(in_ready), 0);
    chk("rst sel", 32'(out_sel), 0);
    chk("rst bit", 32'(out_bit), 0);
    chk("rst last", 32'(out_last), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post rst ready", 32'(in_ready), 1);

    for (int v = 0; v < 7; v++) begin
      run_word($sformatf("vec%0d", v),
               vecs[v].word, vecs[v].bits, vecs[v].par);
    end

    // back-to-back with noisy in_valid/in_data mid-word
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'hACF1;
    #1;
    chk("b2b load ready", 32'(in_ready), 1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = (i == 15) ? 1'b1 : i[0];
      in_data  = (i == 15) ? 16'hCBE3 : 16'($urandom);
      #1;
      beat_chk("b2b w1", i, vecs[0].bits[i]);
      chk($sformatf("b2b w1 b%0d ready", i), 32'(in_ready),
          (i == 15) ? 32'(LAST15) : 0);
    end
`ifdef PARITY_EN
    @(negedge clk);
    #1;
    par_chk("b2b w1", 1'b1);
    chk("b2b par ready", 32'(in_ready), 1);
`endif
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      #1;
      beat_chk("b2b w2", i, vecs[1].bits[i]);
    end
`ifdef PARITY_EN
    @(negedge clk);
    #1;
    par_chk("b2b w2", 1'b0);
`endif
    @(negedge clk);
    #1;
    idle_chk("b2b end");

    // backpressure at sel=5
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'hACF1;
    #1;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          in_valid  = 1'b0;
          out_ready = 1'b0;
          #1;
          beat_chk($sformatf("bp stall%0d", k), 5, 1'b1);
          chk($sformatf("bp stall%0d ready", k), 32'(in_ready), 0);
        end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      beat_chk("bp", i, vecs[0].bits[i]);
    end
`ifdef PARITY_EN
    @(negedge clk);
    #1;
    par_chk("bp", 1'b1);
`endif
    @(negedge clk);
    #1;
    idle_chk("bp end");

    // asynchronous reset in the middle of a word
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'hCBE3;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      beat_chk("mid", i, vecs[1].bits[i]);
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid rst valid", 32'(out_valid), 0);
    chk("mid rst sel", 32'(out_sel), 0);
    chk("mid rst ready", 32'(in_ready), 0);
    chk("mid rst bit", 32'(out_bit), 0);
    chk("mid rst last", 32'(out_last), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_word("after rst", 16'hACF1, vecs[0].bits, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_serializer.md
Name: mux_serializer

Overview:
- Parallel-to-serial stage that feeds a 16-to-1 data/select mux path.
- Accepts a 16-bit word over a valid/ready handshake and drives a 4-bit select counter from 0 to 15.
- Emits one selected bit per beat downstream, with valid/ready and a last-beat flag.
- Produces the w/s stimulus pattern in hardware, so the mux is exercised by a sequencer instead of a bench loop.

Parameters:
- WIDTH, 16, data word width; must equal 2**SEL_W.
- SEL_W, 4, select counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  [0:WIDTH-1]  parallel word; index 0 is the leftmost bit of a hex literal.
- out_valid  output  1  out_bit/out_sel valid.
- out_ready  input  1  downstream accepts the current beat.
- out_bit  output  1  selected bit, equal to held_word[out_sel].
- out_sel  output  SEL_W  current select value.
- out_last  output  1  final beat of the word.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, held word=0, sel=0. out_valid=0, out_bit=0, out_sel=0, out_last=0. in_ready forced 0 while rst_n is low.
- States: IDLE, SHIFT (plus PAR when PARITY_EN is defined).
- IDLE behaviour:
  - in_ready=1, out_valid=0, out_bit=0.
  - Handshake (in_valid & in_ready) at edge N: capture in_data, sel<=0, state<=SHIFT.
  - First beat is valid in the cycle after edge N, so latency is 1 cycle.
- SHIFT behaviour:
  - out_valid=1; out_bit=held[sel], combinational from registers; out_last=(sel==WIDTH-1).
  - Beat fires on out_valid & out_ready. If sel<WIDTH-1: sel<=sel+1. If sel==WIDTH-1: go to IDLE, unless a new word is accepted on the same edge.
  - Back-to-back: in_ready = IDLE | (SHIFT & out_last & out_ready). This combinational out_ready->in_ready path is intentional.
  - If a word is accepted on the last beat: capture it, sel wraps to 0, stay in SHIFT. No bubble; 16 beats per word sustained.
- Backpressure: while out_ready=0, sel, held word, out_bit and out_last stay stable. in_valid is ignored unless in_ready=1.
- Select arithmetic: sel is SEL_W bits unsigned. Wrap to 0 happens only via a new capture or via IDLE, never by free-running overflow.
- in_data changing while not handshaked has no effect on outputs.
- Reset mid-word: word is discarded and outputs take reset values immediately. First post-reset word starts at sel=0.

Optional Feature:
- Macro PARITY_EN.
- Defined:
  - After the sel==WIDTH-1 beat fires, enter PAR for one beat.
  - In PAR: out_bit = even-parity bit (XOR of all held bits), out_sel=WIDTH-1 (held), out_last=1. out_last is 0 on data beat 15.
  - Back-to-back acceptance moves to the PAR beat: in_ready = IDLE | (PAR & out_ready).
  - Throughput is 17 beats per word.
- Undefined: no PAR state; behaviour exactly as above.

Decomposition:
- Shared package mux_ser_pkg:
  - localparams WIDTH=16, SEL_W=4.
  - State enum type: IDLE, SHIFT, PAR. PAR is always declared, used only under PARITY_EN.
- One natural sub-module: sel_mux, a WIDTH-to-1 combinational mux (inputs w[0:WIDTH-1], s[SEL_W-1:0]; output f=w[s]) instantiated for out_bit.
- Counter, FSM and holding register live in the top.

Test Plan:
- Single word, out_ready tied 1:
  - Stimulus: 16'hACF1.
  - Required: out_bit over sel 0..15 = 1,0,1,0,1,1,0,0,1,1,1,1,0,0,0,1; out_last only at sel=15; out_valid drops next cycle; in_ready=1.
- Back-to-back:
  - Stimulus: 16'hACF1 then 16'hCBE3 held valid.
  - Required: 32 consecutive valid beats with no gap. Second word bits = 1,1,0,0,1,0,1,1,1,1,1,0,0,0,1,1. in_ready pulses high on the ACF1 last beat.
- Backpressure:
  - Stimulus: 16'hACF1, out_ready=0 for 3 cycles at sel=5.
  - Required: out_sel=5 and out_bit=1 held stable for all 3 cycles; sequence resumes intact.
- Reset mid-word:
  - Stimulus: rst_n low asynchronously at sel=7 of 16'hCBE3.
  - Required: out_valid=0 and out_sel=0 immediately, without waiting for a clock edge. Next word 16'hACF1 starts at sel=0 with out_bit=1.
- PARITY_EN defined:
  - Stimulus: 16'hACF1, then 16'hCBE3.
  - Required: 17th beat out_bit=1 (9 ones) with out_last=1. For CBE3, parity beat out_bit=0 (10 ones). out_last=0 at sel=15.
- Handshake hygiene:
  - Stimulus: in_valid toggling with in_data changing while the block is in SHIFT (not on the last beat).
  - Required: in_ready=0 and the held word is unchanged.
